group_scan_cmd_deser: RTL
=========================

// Module: group_scan_cmd_deser
// PURPOSE
//  Upstream stage of the group memory/register interface. Deserialises scan-chain command frames into a parallel
//  static_wen/ren/addr/wdata transaction and signals each new command by toggling static_scan_id.
//  Holds the command until static_ready, captures read data and presents it serially on scan_out.
//  One command in flight at a time.
// PARAMETERS
//  ADDR_W       20    static address width
//  DATA_W       32    static data width
//  TIMEOUT_CYC  1024  WAIT-state cycle limit (used only with SCAN_TIMEOUT_EN)
//  FRAME_W      (localparam) 2+ADDR_W+DATA_W = 54; shift-register length
// PORTS
//  clk            in   1       single clock
//  rst            in   1       asynchronous, active-high reset
//  scan_en        in   1       shift enable; shifts one bit per clk
//  scan_in        in   1       serial data in, LSB of frame first
//  scan_update    in   1       1-cycle strobe: issue command held in shift register
//  scan_out       out  1       serial out = sr[0]
//  busy           out  1       command issued, awaiting static_ready
//  err            out  1       sticky protocol error
//  static_wen     out  1       write request, level, held until ready
//  static_ren     out  1       read request, level, held until ready
//  static_addr    out  ADDR_W  request address, stable while busy
//  static_wdata   out  DATA_W  write data, stable while busy
//  static_rdata   in   DATA_W  read data, valid with static_ready
//  static_ready   in   1       completion strobe from downstream
//  static_scan_id out  1       toggles once per issued command (downstream synchronises and edge-detects it)
// BEHAVIOUR
//  Reset: sr=0, state IDLE. All outputs 0: scan_out, busy, err, static_wen, static_ren, static_addr,
//   static_wdata, static_scan_id.
//  Frame layout: sr[DATA_W-1:0]=wdata; sr[DATA_W+ADDR_W-1:DATA_W]=addr; sr[FRAME_W-2]=ren; sr[FRAME_W-1]=wen.
//  Shift: IDLE and scan_en -> sr <= {scan_in, sr[FRAME_W-1:1]}. FRAME_W shifts load one full frame.
//  FSM IDLE -> WAIT -> IDLE.
//   IDLE, scan_update=1, scan_en=0, exactly one of wen/ren set: accepted.
//    On that edge: latch static_* from sr, toggle static_scan_id, busy=1, err=0, go to WAIT.
//    Request is visible 1 cycle after the update strobe.
//   IDLE, scan_update with wen=ren=0 or wen=ren=1: rejected. Set err; no issue, no toggle.
//   WAIT, static_ready=1: static_wen=0, static_ren=0, busy=0, go to IDLE in the same edge.
//    Read: sr <= {zeros, static_rdata}, so scan_out = rdata[0] on the next cycle.
//    Write: sr unchanged.
//   static_ready in IDLE is ignored and does not set err.
//  Boundary rules:
//   scan_en and scan_update in the same cycle: shift wins, update dropped, set err.
//   scan_update or scan_en while busy: ignored (sr and static_* unchanged), set err.
//   static_ready in the same cycle as the accepting update: not a completion; first ready counted is in WAIT.
//   static_addr and static_wdata hold their last values after completion; only wen/ren drop.
//   rst mid-WAIT: immediate return to reset values, including static_scan_id = 0.
//    The downstream synchroniser sees this as a toggle only if static_scan_id was 1.
// CONFIGURATION
//  SCAN_TIMEOUT_EN defined:
//   counter clears on entering WAIT and increments each WAIT cycle.
//   When it reaches TIMEOUT_CYC-1 without ready: drop wen/ren, busy=0, err=1, sr <= {zeros, 32'hDEAD_BEEF},
//    go to IDLE.
//   A late static_ready in IDLE is then ignored.
//  SCAN_TIMEOUT_EN undefined: no counter; WAIT persists until static_ready or rst.
// TESTING
//  1. Shift 54-bit write frame (wen=1, addr=20'h00123, wdata=32'hA5A5_0F0F), pulse update
//     -> next cycle static_wen=1, addr/wdata match, scan_id 0->1, busy=1.
//     Ready after 5 cycles -> wen=0, busy=0.
//  2. Read frame with addr=20'h00800; ready with rdata=32'h1234_5678
//     -> next 32 scan_en cycles shift out 0x12345678 LSB first, then zeros; scan_id toggles back to 0.
//  3. Frame with wen=ren=1, then update -> err=1, no request, scan_id unchanged.
//     A following valid update clears err.
//  4. While busy: pulse update and scan_en -> err=1; static_* and sr unchanged; ready completes normally.
//  5. SCAN_TIMEOUT_EN, TIMEOUT_CYC=16, read, no ready -> busy drops after 16 WAIT cycles, err=1,
//     scan_out shifts 32'hDEAD_BEEF.
//  6. Assert rst 3 cycles into WAIT -> all outputs 0 immediately; post-reset write frame issues normally.

Source files
------------

// File: rtl/group_scan_cmd_deser_if.sv
// Scan-command deserialiser bus: scan-chain side plus static request/response side.
// slave = deserialiser view, master = scan controller / downstream view.
interface group_scan_cmd_deser_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              scan_en;
    logic              scan_in;
    logic              scan_update;
    logic              scan_out;
    logic              busy;
    logic              err;
    logic              static_wen;
    logic              static_ren;
    logic [ADDR_W-1:0] static_addr;
    logic [DATA_W-1:0] static_wdata;
    logic [DATA_W-1:0] static_rdata;
    logic              static_ready;
    logic              static_scan_id;

    modport slave (
        input  scan_en, scan_in, scan_update, static_rdata, static_ready,
        output scan_out, busy, err, static_wen, static_ren, static_addr,
               static_wdata, static_scan_id
    );

    modport master (
        output scan_en, scan_in, scan_update, static_rdata, static_ready,
        input  scan_out, busy, err, static_wen, static_ren, static_addr,
               static_wdata, static_scan_id
    );
endinterface

// File: rtl/group_scan_cmd_deser.sv
// Scan-chain command deserialiser: shifts in {wen,ren,addr,wdata}, issues one request, returns read data serially.
// Optional WAIT timeout enabled by defining SCAN_TIMEOUT_EN.
module group_scan_cmd_deser #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    group_scan_cmd_deser_if.slave bus
);
    localparam int FRAME_W = 2 + ADDR_W + DATA_W;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  sr_q, sr_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                id_q, id_d;

`ifdef SCAN_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        busy_d  = busy_q;
        err_d   = err_q;
        wen_d   = wen_q;
        ren_d   = ren_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        id_d    = id_q;
`ifdef SCAN_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Shift takes priority; a coincident update is a protocol error and is dropped.
                if (bus.scan_en) begin
                    sr_d = {bus.scan_in, sr_q[FRAME_W-1:1]};
                    if (bus.scan_update) err_d = 1'b1;
                end else if (bus.scan_update) begin
                    if (sr_q[FRAME_W-1] ^ sr_q[FRAME_W-2]) begin
                        wen_d   = sr_q[FRAME_W-1];
                        ren_d   = sr_q[FRAME_W-2];
                        addr_d  = sr_q[DATA_W+ADDR_W-1:DATA_W];
                        wdata_d = sr_q[DATA_W-1:0];
                        id_d    = ~id_q;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_WAIT;
`ifdef SCAN_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.scan_en || bus.scan_update) err_d = 1'b1;
`ifdef SCAN_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus.static_ready) begin
                    if (ren_q) sr_d = {{(FRAME_W-DATA_W){1'b0}}, bus.static_rdata};
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef SCAN_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    sr_d    = {{(FRAME_W-DATA_W){1'b0}}, DATA_W'(32'hDEAD_BEEF)};
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign bus.scan_out       = sr_q[0];
    assign bus.busy           = busy_q;
    assign bus.err            = err_q;
    assign bus.static_wen     = wen_q;
    assign bus.static_ren     = ren_q;
    assign bus.static_addr    = addr_q;
    assign bus.static_wdata   = wdata_q;
    assign bus.static_scan_id = id_q;
endmodule
